alu_seq_param: RTL and testbench

Parametrised, handshaked successor to the 16-bit single-cycle ALU. It registers every result and the Z/V/N flags, and adds an iterative multi-cycle multiply. WIDTH, lane size and saturation mode are configurable. It sits in the execute stage between register-file read and writeback/memory-address logic, and stalls issue through `in_ready` while a multiply is in flight.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/paddsb_lanes.sv | 29 ++
 rtl/alu_seq_param.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_param.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states
// and helpers that decide which flags each opcode updates.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD      = 4'h0,
    OP_SUB      = 4'h1,
    OP_XOR      = 4'h2,
    OP_RED      = 4'h3,
    OP_SLL      = 4'h4,
    OP_SRA      = 4'h5,
    OP_ROR      = 4'h6,
    OP_PADDSB   = 4'h7,
    OP_ADDR     = 4'h8,
    OP_ADDR_ALT = 4'h9,
    OP_LHB      = 4'hA,
    OP_LLB      = 4'hB,
    OP_MUL      = 4'hC
  } opcode_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  function automatic logic writes_z(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_MUL: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic writes_vn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/paddsb_lanes.sv
// Lane-parallel signed saturating add; lanes are LANE bits wide with no carry between them.
module paddsb_lanes
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic [LANE-1:0] LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0] LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  for (genvar g = 0; g < int'(WIDTH / LANE); g++) begin : g_lane
    logic [LANE-1:0] la;
    logic [LANE-1:0] lb;
    logic [LANE-1:0] ls;
    logic            ovf;

    assign la  = a[g*LANE +: LANE];
    assign lb  = b[g*LANE +: LANE];
    assign ls  = la + lb;
    assign ovf = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
    assign y[g*LANE +: LANE] = ovf ? (la[LANE-1] ? LANE_MIN : LANE_MAX) : ls;
  end

endmodule

// File: rtl/alu_seq_param.sv
// Execute-stage ALU with registered result/flags, valid/ready issue handshake and an
// iterative shift-add multiply that stalls issue while it runs.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LANE    = 4,
  parameter int unsigned SAT_ADD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [7:0]       imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] rd,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SMAX      = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ADDR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic [2:0]         flags_q, flags_d;
  logic               ov_q, ov_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   add_sum, sub_dif, red_sum, imm_sext, paddsb_res;
  logic [WIDTH-1:0]   alu_res, mul_step;
  logic               add_ovf, sub_ovf, alu_ovf;
  logic [2:0]         alu_flags;
  logic [SH_W-1:0]    shamt;

  paddsb_lanes #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_paddsb (
    .a (rs),
    .b (rt),
    .y (paddsb_res)
  );

  always_comb begin
    add_sum  = rs + rt;
    sub_dif  = rs - rt;
    add_ovf  = (rs[WIDTH-1] == rt[WIDTH-1]) && (add_sum[WIDTH-1] != rs[WIDTH-1]);
    sub_ovf  = (rs[WIDTH-1] != rt[WIDTH-1]) && (sub_dif[WIDTH-1] != rs[WIDTH-1]);
    shamt    = rt[SH_W-1:0];
    imm_sext = {{(WIDTH-4){imm[3]}}, imm[3:0]};
    red_sum  = '0;
    for (int unsigned i = 0; i < WIDTH / 8; i++) begin
      red_sum = red_sum + WIDTH'($signed(rs[8*i +: 8])) + WIDTH'($signed(rt[8*i +: 8]));
    end

    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_ovf = add_ovf;
        alu_res = (SAT_ADD != 0 && add_ovf) ? (rs[WIDTH-1] ? SMIN : SMAX) : add_sum;
      end
      OP_SUB: begin
        alu_ovf = sub_ovf;
        alu_res = (SAT_ADD != 0 && sub_ovf) ? (rs[WIDTH-1] ? SMIN : SMAX) : sub_dif;
      end
      OP_XOR:              alu_res = rs ^ rt;
      OP_RED:              alu_res = red_sum;
      OP_SLL:              alu_res = rs << shamt;
      OP_SRA:              alu_res = $signed(rs) >>> shamt;
      // shift by WIDTH yields zero in this context, so ROR by 0 returns rs
      OP_ROR:              alu_res = (rs >> shamt) | (rs << (WIDTH - shamt));
      OP_PADDSB:           alu_res = paddsb_res;
      OP_ADDR, OP_ADDR_ALT: alu_res = (rs & ADDR_MASK) + (imm_sext << 1);
      OP_LHB: begin
        alu_res = rs;
        alu_res[WIDTH-1 -: 8] = imm;
      end
      OP_LLB: begin
        alu_res = rs;
        alu_res[7:0] = imm;
      end
      default:             alu_res = '0;
    endcase

    alu_flags = flags_q;
    if (writes_z(opcode)) alu_flags[FLAG_Z] = (alu_res == '0);
    if (writes_vn(opcode)) begin
      alu_flags[FLAG_V] = alu_ovf;
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
    end
  end

  assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    flags_d  = flags_q;
    ov_d     = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            // First partial product is folded into the load so the last of the
            // WIDTH steps is written WIDTH-1 cycles later, as the counter hits 1.
            acc_d    = rt[0] ? rs : '0;
            mcand_d  = rs << 1;
            mplier_d = rt >> 1;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_MUL;
          end else begin
            rd_d    = alu_res;
            flags_d = alu_flags;
            ov_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(2)) begin
          rd_d            = mul_step;
          flags_d[FLAG_Z] = (mul_step == '0);
          ov_d            = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      flags_q  <= '0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      flags_q  <= flags_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign out_valid = ov_q;
  assign rd        = rd_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed scoreboard bench for alu_seq_param at WIDTH=16, LANE=4, SAT_ADD=1.
module tb_alu_seq_param;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  rs;
  logic [W-1:0]  rt;
  logic [7:0]    imm;
  logic          out_valid;
  logic [W-1:0]  rd;
  logic [2:0]    flags;
  logic          busy;

  alu_seq_param #(
    .WIDTH   (W),
    .LANE    (4),
    .SAT_ADD (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .imm       (imm),
    .out_valid (out_valid),
    .rd        (rd),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [15:0] rd;
    logic [2:0]  fl;
  } exp_t;

  exp_t        scb[$];
  logic [2:0]  mflags;
  int          checks;
  int          errors;
  logic        seen_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {N,V,Z} in mflags, updated in issue order.
  task automatic predict(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] im, output logic [15:0] r);
    int s, x, y, n;
    logic v;
    n = int'(b[3:0]);
    r = '0;
    case (op)
      4'h0, 4'h1: begin
        x = $signed(a);
        y = $signed(b);
        s = (op == 4'h0) ? x + y : x - y;
        v = (s > 32767) || (s < -32768);
        r = v ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'(s);
        mflags[1] = v;
        mflags[2] = r[15];
      end
      4'h2: r = a ^ b;
      4'h3: begin
        s = 0;
        for (int k = 0; k < 2; k++) begin
          x = $signed(a[8*k +: 8]);
          y = $signed(b[8*k +: 8]);
          s = s + x + y;
        end
        r = 16'(s);
      end
      4'h4: begin r = a; repeat (n) r = {r[14:0], 1'b0}; end
      4'h5: begin r = a; repeat (n) r = {r[15], r[15:1]}; end
      4'h6: begin r = a; repeat (n) r = {r[0], r[15:1]}; end
      4'h7: begin
        for (int l = 0; l < 4; l++) begin
          x = $signed(a[4*l +: 4]);
          y = $signed(b[4*l +: 4]);
          s = x + y;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*l +: 4] = 4'(s);
        end
      end
      4'h8, 4'h9: begin
        x = $signed(im[3:0]);
        s = int'(a & 16'hFFFE) + 2 * x;
        r = 16'(s);
      end
      4'hA: r = {im, a[7:0]};
      4'hB: r = {a[15:8], im};
      4'hC: r = 16'(32'(a) * 32'(b));
      default: r = '0;
    endcase
    if (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hC}) mflags[0] = (r == 16'h0000);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    seen_ov = out_valid;
    if (out_valid) begin
      if (scb.size() == 0) begin
        chk("spurious_ov", 32'(out_valid), 32'd0);
      end else begin
        e = scb.pop_front();
        chk({e.tag, "_rd"}, 32'(rd), 32'(e.rd));
        chk({e.tag, "_flags"}, 32'(flags), 32'(e.fl));
      end
    end
  endtask

  task automatic push_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] im);
    exp_t e;
    logic [15:0] r;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    opcode   = op;
    rs       = a;
    rt       = b;
    imm      = im;
    in_valid = 1'b1;
    predict(op, a, b, im, r);
    e.tag = tag;
    e.rd  = r;
    e.fl  = mflags;
    scb.push_back(e);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [7:0] im);
    push_op(tag, op, a, b, im);
    tick();
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b);
    int  low;
    bit  done;
    push_op(tag, 4'hC, a, b, 8'h00);
    tick();
    opcode = 4'h2;
    rs     = 16'hFFFF;
    rt     = 16'h0F0F;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) done = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    in_valid = 1'b0;
    chk({tag, "_done_in_time"}, 32'(done), 32'd1);
    chk({tag, "_ready_low_cycles"}, 32'(low), 32'(W - 1));
    chk({tag, "_ov_with_ready"}, 32'(seen_ov), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    checks   = 0;
    errors   = 0;
    mflags   = 3'b000;
    seen_ov  = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    opcode   = 4'h0;
    rs       = '0;
    rt       = '0;
    imm      = '0;
    #22;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    issue("add_sat", 4'h0, 16'h7FFF, 16'h0001, 8'h00);
    issue("sub_zero", 4'h1, 16'h0005, 16'h0005, 8'h00);
    issue("paddsb_pos", 4'h7, 16'h7777, 16'h1111, 8'h00);
    issue("paddsb_neg", 4'h7, 16'h8888, 16'h8888, 8'h00);
    issue("addr8", 4'h8, 16'h1001, 16'h0000, 8'h0F);
    issue("addr9", 4'h9, 16'h2000, 16'h0000, 8'h07);
    issue("lhb", 4'hA, 16'h1234, 16'h0000, 8'hAB);
    issue("llb", 4'hB, 16'h1234, 16'h0000, 8'hCD);
    issue("red", 4'h3, 16'h80FF, 16'h0102, 8'h00);
    issue("sub_sat_neg", 4'h1, 16'h8000, 16'h0001, 8'h00);
    issue("add_neg", 4'h0, 16'hFFF0, 16'h0005, 8'h00);

    pulses = 0;
    issue("b2b_xor", 4'h2, 16'hA5A5, 16'h0FF0, 8'h00);
    pulses += int'(seen_ov);
    issue("b2b_sll", 4'h4, 16'h0123, 16'h0004, 8'h00);
    pulses += int'(seen_ov);
    issue("b2b_ror", 4'h6, 16'h1234, 16'h0004, 8'h00);
    pulses += int'(seen_ov);
    chk("b2b_pulses", 32'(pulses), 32'd3);
    issue("sra", 4'h5, 16'h8000, 16'h0003, 8'h00);
    issue("ror0", 4'h6, 16'hBEEF, 16'h0010, 8'h00);
    issue("sll0", 4'h4, 16'h0000, 16'h0000, 8'h00);
    in_valid = 1'b0;
    tick();

    run_mul("mul", 16'h0012, 16'h0034);
    tick();
    run_mul("mul_zero", 16'h1234, 16'h0000);
    tick();
    issue("rsv", 4'hE, 16'h1111, 16'h2222, 8'h33);
    issue("lhb2", 4'hA, 16'h5678, 16'h0000, 8'h9A);
    in_valid = 1'b0;
    tick();

    chk("pre_abort_in_ready", 32'(in_ready), 32'd1);
    opcode   = 4'hC;
    rs       = 16'h0003;
    rt       = 16'h0005;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    mflags = 3'b000;
    chk("abort_rd", 32'(rd), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (W + 2) tick();

    issue("post_abort_add", 4'h0, 16'h1234, 16'h1111, 8'h00);
    in_valid = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
